// File: rtl/spi_ram_pkg.sv
// Shared constants for the SPI-attached RAM: command opcodes, word widths, TX FSM encoding.
package spi_ram_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam logic [0:0] TX_IDLE    = 1'b0;
    localparam logic [0:0] TX_HOLD_ST = 1'b1;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM with a read-enabled registered output; contents are never reset.
module spi_ram_mem
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic                 i_re,
    input  logic [ADDR_SIZE-1:0] i_addr,
    input  logic [DATA_W-1:0]    i_din,
    output logic [DATA_W-1:0]    o_dout
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic [DATA_W-1:0] r_dout;

    // The output register only moves on a read so it can serve as the held TX word.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_din;
        if (i_re) r_dout <= r_mem[i_addr];
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/spi_ram.sv
// Command decoder for the SPI slave word stream: address pointers, RAM access, TX hold FSM.
//   state      | meaning
//   TX_IDLE    | o_tx_valid low, o_tx_data holds last read word
//   TX_HOLD_ST | o_tx_valid high while r_hold_cnt counts down to zero
module spi_ram
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int TX_HOLD   = 9
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [CMD_W-1:0]  i_rx_data,
    input  logic              i_rx_valid,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_valid
);

    localparam int CNT_W = $clog2(TX_HOLD + 1);

    logic [ADDR_SIZE-1:0] r_wr_ptr;
    logic [ADDR_SIZE-1:0] r_rd_ptr;
    logic [0:0]           r_state;
    logic [CNT_W-1:0]     r_hold_cnt;
    logic                 r_tx_loaded;

    logic [1:0]           w_op;
    logic [ADDR_SIZE-1:0] w_payload;
    logic                 w_wr_addr;
    logic                 w_wr_data;
    logic                 w_rd_addr;
    logic                 w_rd_data;
    logic [ADDR_SIZE-1:0] w_mem_addr;
    logic [DATA_W-1:0]    w_mem_dout;

    assign w_op      = i_rx_data[CMD_W-1:CMD_W-2];
    assign w_payload = i_rx_data[ADDR_SIZE-1:0];
    assign w_wr_addr = i_rx_valid && (w_op == OP_WR_ADDR);
    assign w_wr_data = i_rx_valid && (w_op == OP_WR_DATA);
    assign w_rd_addr = i_rx_valid && (w_op == OP_RD_ADDR);
    assign w_rd_data = i_rx_valid && (w_op == OP_RD_DATA);

    assign w_mem_addr = w_wr_data ? r_wr_ptr : r_rd_ptr;

    spi_ram_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .i_clk  (i_clk),
        .i_we   (w_wr_data),
        .i_re   (w_rd_data),
        .i_addr (w_mem_addr),
        .i_din  (i_rx_data[DATA_W-1:0]),
        .o_dout (w_mem_dout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_addr) r_wr_ptr <= w_payload;
            if (w_wr_data) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_addr) r_rd_ptr <= w_payload;
            if (w_rd_data) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= TX_IDLE;
            r_hold_cnt  <= '0;
            r_tx_loaded <= 1'b0;
        end else begin
            if (w_rd_data) r_tx_loaded <= 1'b1;
            if (w_rd_data) begin
                r_state    <= TX_HOLD_ST;
                r_hold_cnt <= CNT_W'(TX_HOLD - 1);
            end else if (r_state == TX_HOLD_ST) begin
                if (i_rx_valid || (r_hold_cnt == '0)) begin
                    r_state    <= TX_IDLE;
                    r_hold_cnt <= '0;
                end else begin
                    r_hold_cnt <= r_hold_cnt - 1'b1;
                end
            end
        end
    end

    // The RAM output register is not reset, so mask it until the first read after reset.
    assign o_tx_data  = r_tx_loaded ? w_mem_dout : '0;
    assign o_tx_valid = (r_state == TX_HOLD_ST);

endmodule

// File: tb/tb_spi_ram.sv
// Self-checking bench for spi_ram: directed scenarios plus a random command stream vs a memory model.
module tb_spi_ram;

    logic       clk;
    logic       rst_n;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int n_cmp;
    int n_fail;

    // reference model
    logic [7:0] m_mem   [256];
    bit         m_known [256];
    int         m_wr;
    int         m_rd;
    int         m_hold;
    logic [7:0] m_data;
    bit         m_data_known;

    spi_ram dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_wr = 0;
        m_rd = 0;
        m_hold = 0;
        m_data = 8'h00;
        m_data_known = 1'b1;
    endtask

    // Drive one word (or an idle cycle) from a negedge, update the model at the posedge,
    // and return at the following negedge where outputs are sampled.
    task automatic step(input bit v, input logic [1:0] op, input logic [7:0] pl);
        rx_valid = v;
        rx_data  = {op, pl};
        @(posedge clk);
        if (v) begin
            case (op)
                2'b00: m_wr = pl;
                2'b01: begin
                    m_mem[m_wr] = pl;
                    m_known[m_wr] = 1'b1;
                    m_wr = (m_wr + 1) % 256;
                end
                2'b10: m_rd = pl;
                default: begin
                    m_data = m_mem[m_rd];
                    m_data_known = m_known[m_rd];
                    m_rd = (m_rd + 1) % 256;
                end
            endcase
            m_hold = (op == 2'b11) ? 9 : 0;
        end else if (m_hold > 0) begin
            m_hold = m_hold - 1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_data = '0;
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tx_valid: got %b want 0", tx_valid);
        end
        n_cmp++;
        if (tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_tx_data: got %h want 00", tx_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cnt;
        step(1, 2'b00, 8'h10);
        step(1, 2'b01, 8'hA5);
        step(1, 2'b10, 8'h10);
        step(1, 2'b11, 8'h00);
        n_cmp++;
        if (tx_data !== 8'hA5 || tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_read: got data %h valid %b want A5 1", tx_data, tx_valid);
        end
        cnt = 1;
        for (int i = 0; i < 12; i++) begin
            step(0, 2'b00, 8'h00);
            if (tx_valid === 1'b1) cnt++;
        end
        n_cmp++;
        if (cnt !== 9) begin
            n_fail++;
            $display("FAIL basic_hold_len: got %0d cycles want 9", cnt);
        end
    endtask

    task automatic test_burst_wrap();
        logic [7:0] exp_v [3];
        exp_v[0] = 8'h11;
        exp_v[1] = 8'h22;
        exp_v[2] = 8'h33;
        step(1, 2'b00, 8'hFE);
        for (int i = 0; i < 3; i++) step(1, 2'b01, exp_v[i]);
        step(1, 2'b10, 8'hFE);
        for (int i = 0; i < 3; i++) begin
            step(1, 2'b11, 8'h5C);
            n_cmp++;
            if (tx_data !== exp_v[i] || tx_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL burst_read%0d: got data %h valid %b want %h 1", i, tx_data, tx_valid, exp_v[i]);
            end
        end
        repeat (10) step(0, 2'b00, 8'h00);
        n_cmp++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_idle: got valid %b want 0", tx_valid);
        end
    endtask

    task automatic test_reload();
        int cnt;
        step(1, 2'b10, 8'hFE);
        step(1, 2'b11, 8'h00);
        repeat (4) step(0, 2'b00, 8'h00);
        n_cmp++;
        if (tx_data !== 8'h11 || tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_first: got data %h valid %b want 11 1", tx_data, tx_valid);
        end
        step(1, 2'b11, 8'h00);
        n_cmp++;
        if (tx_data !== 8'h22) begin
            n_fail++;
            $display("FAIL reload_data: got %h want 22", tx_data);
        end
        cnt = (tx_valid === 1'b1) ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 2'b00, 8'h00);
            if (tx_valid === 1'b1) cnt++;
        end
        n_cmp++;
        if (cnt !== 9) begin
            n_fail++;
            $display("FAIL reload_hold_len: got %0d cycles want 9", cnt);
        end
    endtask

    task automatic test_cut();
        // rd_ptr is 0x00 here, which holds 0x33 from the wrapped burst
        step(1, 2'b11, 8'h00);
        step(0, 2'b00, 8'h00);
        step(1, 2'b00, 8'h05);
        n_cmp++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h33) begin
            n_fail++;
            $display("FAIL cut_short: got valid %b data %h want 0 33", tx_valid, tx_data);
        end
        step(1, 2'b01, 8'h5A);
        step(1, 2'b10, 8'h05);
        step(1, 2'b11, 8'h00);
        n_cmp++;
        if (tx_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL cut_wr_ptr: got %h want 5A", tx_data);
        end
        repeat (10) step(0, 2'b00, 8'h00);
    endtask

    task automatic test_reset_mid_hold();
        step(1, 2'b10, 8'h10);
        step(1, 2'b11, 8'h00);
        step(0, 2'b00, 8'h00);
        step(0, 2'b00, 8'h00);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midhold_reset: got valid %b data %h want 0 00", tx_valid, tx_data);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(1, 2'b11, 8'h00);
        n_cmp++;
        if (tx_data !== 8'h33 || tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_rd0: got data %h valid %b want 33 1", tx_data, tx_valid);
        end
        step(1, 2'b10, 8'h10);
        step(1, 2'b11, 8'h00);
        n_cmp++;
        if (tx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL post_reset_intact: got %h want A5", tx_data);
        end
        repeat (10) step(0, 2'b00, 8'h00);
    endtask

    task automatic test_random();
        bit         v;
        logic [1:0] op;
        logic [7:0] pl;
        for (int i = 0; i < 1000; i++) begin
            v  = ($urandom_range(0, 9) < 7);
            op = 2'($urandom_range(0, 3));
            pl = 8'($urandom);
            step(v, op, pl);
            n_cmp++;
            if (tx_valid !== (m_hold > 0)) begin
                n_fail++;
                $display("FAIL rand_valid[%0d]: got %b want %b", i, tx_valid, (m_hold > 0));
            end
            if (m_data_known) begin
                n_cmp++;
                if (tx_data !== m_data) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d]: got %h want %h", i, tx_data, m_data);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_burst_wrap();
        test_reload();
        test_cut();
        test_reset_mid_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
